fighter_state_fsm: RTL and testbench
====================================

# fighter_state_fsm

Per-player fighter state machine sitting directly upstream of the sprite renderer. Samples the player's debounced left/right/attack buttons once per game frame, sequences movement and the three-phase attack (startup, active, recovery) with parameterised frame durations, and drives the 3-bit fighter state that the renderer turns into sprite position and colour. It also exports hit-window and busy flags for the later collision/scoring logic.

## Interface
- START_FRAMES, 4, frames spent in attack startup (1..31)
- ACTIVE_FRAMES, 2, frames spent in the attack active, hit-capable window (1..31)
- RECOVERY_FRAMES, 6, frames spent in attack recovery (1..31)

- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous and active-low
- frame_tick  in  1  one-clk pulse per game frame; all state advances happen only on this pulse
- btn_left  in  1  debounced, clk-synchronous, active-high
- btn_right  in  1  debounced, clk-synchronous, active-high
- btn_attack  in  1  debounced, clk-synchronous, active-high
- state  out  3  fighter state: 0 IDLE, 1 BACKWARD, 2 FORWARD, 3 ATTACK_START, 4 ATTACK_ACTIVE, 5 ATTACK_RECOVERY; 6 and 7 are never driven
- hit_active  out  1  high exactly while state == ATTACK_ACTIVE
- attack_busy  out  1  high while state is 3, 4 or 5
- attack_pulse  out  1  one-clk pulse on the clk where state enters ATTACK_ACTIVE

## Operation
- Reset values: state = IDLE, hit_active = 0, attack_busy = 0, attack_pulse = 0, frame counter = 0, attack_prev = 0.
- Without frame_tick, all registers hold, and attack_pulse is 0.
- On every frame_tick, regardless of state, attack_prev <= btn_attack. attack_edge = btn_attack & ~attack_prev, evaluated on that tick.
- IDLE / BACKWARD / FORWARD are evaluated on a tick in this priority order:
  - attack_edge: go to ATTACK_START and load counter = START_FRAMES-1.
  - btn_left & ~btn_right: go to BACKWARD.
  - btn_right & ~btn_left: go to FORWARD.
  - Otherwise, including both pressed: go to IDLE.
- Attack states are evaluated on a tick:
  - Counter != 0: decrement the counter and stay in the state.
  - Counter == 0: advance to the next phase.
  - ATTACK_START → ATTACK_ACTIVE loads ACTIVE_FRAMES-1.
  - ATTACK_ACTIVE → ATTACK_RECOVERY loads RECOVERY_FRAMES-1.
  - ATTACK_RECOVERY → movement resolution using the same priority list as above, except that attack_edge is evaluated normally, so a fresh press on the final recovery tick chains into a new ATTACK_START.
- Movement buttons are ignored throughout all attack states. Attack presses during an attack are not buffered.
- A held btn_attack never retriggers; it must be released for at least one tick and then pressed again.
- Counter width is 5 bits, unsigned, and never underflows. Each phase occupies exactly its parameter count of frames.
- If state ever holds 6 or 7, it returns to IDLE on the next clk, without waiting for a tick, and the counter is cleared.
- An rst_n assertion mid-attack immediately forces all reset values. After release, the first tick is treated like any tick from IDLE.

## Timing
- All outputs are registered. state changes on the clk edge that samples frame_tick = 1, i.e. it is valid on the cycle after the tick cycle.
- hit_active and attack_busy are registered alongside state, with no skew relative to state.
- attack_pulse is asserted in the same cycle that state first reads ATTACK_ACTIVE and lasts 1 clk.
- Total attack length is START_FRAMES + ACTIVE_FRAMES + RECOVERY_FRAMES ticks (defaults: 12).
- Back-to-back frame_tick on consecutive clks is legal; each tick is a full frame step.

## Structure
- Shared package footsies_pkg holds:
  - the 3-bit state localparams (S_IDLE..S_ATTACK_RECOVERY), also used by the sprite renderer;
  - the FRAME_CNT_W = 5 constant.
- One natural sub-module, frame_down_counter: loadable 5-bit down-counter with tick enable and a zero flag.
- The edge detect and FSM stay in the top module.

## Test plan
- Reset mid-ATTACK_ACTIVE: assert rst_n = 0 asynchronously → state = 0, hit_active = 0, attack_busy = 0 immediately. Release, then apply 3 ticks with no buttons → state stays 0.
- Basic attack at defaults: press attack before tick k → state 3 after ticks k..k+3, state 4 after ticks k+4..k+5 with attack_pulse one clk after tick k+4, state 5 after ticks k+6..k+11, state 0 after tick k+12.
- Movement: right held for 5 ticks → state 2 each frame. Left + right together → state 0. Left only → state 1. No change occurs between ticks.
- Hold attack through the whole attack (15 ticks) → exactly one attack sequence, then state 0. Release for 1 tick and press again → new state 3.
- Press right during ATTACK_START → ignored, state sequence unchanged. With right still held at the recovery-exit tick → state 2.
- Chain: attack_edge lands on the final recovery tick → state goes 5 → 3 directly. Parameters START = 1, ACTIVE = 1, RECOVERY = 1 → 3-tick attack, with attack_pulse present.

Source files
------------

// File: rtl/footsies_pkg.sv
// Shared fighter definitions: 3-bit state codes (also decoded by the sprite renderer),
// frame counter width and the movement-resolution helper.
package footsies_pkg;

  localparam int FRAME_CNT_W = 5;

  localparam logic [2:0] S_IDLE            = 3'd0;
  localparam logic [2:0] S_BACKWARD        = 3'd1;
  localparam logic [2:0] S_FORWARD         = 3'd2;
  localparam logic [2:0] S_ATTACK_START    = 3'd3;
  localparam logic [2:0] S_ATTACK_ACTIVE   = 3'd4;
  localparam logic [2:0] S_ATTACK_RECOVERY = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE            = S_IDLE,
    ST_BACKWARD        = S_BACKWARD,
    ST_FORWARD         = S_FORWARD,
    ST_ATTACK_START    = S_ATTACK_START,
    ST_ATTACK_ACTIVE   = S_ATTACK_ACTIVE,
    ST_ATTACK_RECOVERY = S_ATTACK_RECOVERY
  } state_e;

  // Opposing directions cancel out to IDLE.
  function automatic state_e resolve_move(input logic left, input logic right);
    if (left && !right) return ST_BACKWARD;
    if (right && !left) return ST_FORWARD;
    return ST_IDLE;
  endfunction

endpackage

// File: rtl/frame_down_counter.sv
// Loadable down-counter for attack phase durations; one-clk update, priority clear > load > tick.
// Decrement saturates at zero; zero flag is combinational from the count register.
module frame_down_counter
  import footsies_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick,
  input  logic                   load,
  input  logic                   clear,
  input  logic [FRAME_CNT_W-1:0] load_val,
  output logic                   zero
);

  logic [FRAME_CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/fighter_state_fsm.sv
// Per-player fighter FSM: movement plus three-phase attack, advanced once per frame_tick.
// All outputs registered, valid the clk after the tick; no backpressure, ticks may arrive back-to-back.
module fighter_state_fsm
  import footsies_pkg::*;
#(
  parameter int START_FRAMES    = 4,
  parameter int ACTIVE_FRAMES   = 2,
  parameter int RECOVERY_FRAMES = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_attack,
  output logic [2:0] state,
  output logic       hit_active,
  output logic       attack_busy,
  output logic       attack_pulse
);

  localparam logic [FRAME_CNT_W-1:0] START_LD    = FRAME_CNT_W'(START_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] ACTIVE_LD   = FRAME_CNT_W'(ACTIVE_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] RECOVERY_LD = FRAME_CNT_W'(RECOVERY_FRAMES - 1);

  state_e                 state_q, state_nxt;
  logic                   attack_prev;
  logic                   attack_edge;
  logic                   cnt_load, cnt_dec, cnt_clr, cnt_zero;
  logic [FRAME_CNT_W-1:0] cnt_load_val;

  assign attack_edge = btn_attack & ~attack_prev;

  frame_down_counter u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (cnt_dec),
    .load     (cnt_load),
    .clear    (cnt_clr),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_nxt    = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    cnt_clr      = 1'b0;
    case (state_q)
      ST_IDLE, ST_BACKWARD, ST_FORWARD: begin
        if (frame_tick) begin
          if (attack_edge) begin
            state_nxt    = ST_ATTACK_START;
            cnt_load     = 1'b1;
            cnt_load_val = START_LD;
          end else begin
            state_nxt = resolve_move(btn_left, btn_right);
          end
        end
      end
      ST_ATTACK_START: begin
        if (frame_tick) begin
          if (!cnt_zero) begin
            cnt_dec = 1'b1;
          end else begin
            state_nxt    = ST_ATTACK_ACTIVE;
            cnt_load     = 1'b1;
            cnt_load_val = ACTIVE_LD;
          end
        end
      end
      ST_ATTACK_ACTIVE: begin
        if (frame_tick) begin
          if (!cnt_zero) begin
            cnt_dec = 1'b1;
          end else begin
            state_nxt    = ST_ATTACK_RECOVERY;
            cnt_load     = 1'b1;
            cnt_load_val = RECOVERY_LD;
          end
        end
      end
      ST_ATTACK_RECOVERY: begin
        if (frame_tick) begin
          if (!cnt_zero) begin
            cnt_dec = 1'b1;
          end else if (attack_edge) begin
            // A fresh press on the exit frame chains straight into a new attack.
            state_nxt    = ST_ATTACK_START;
            cnt_load     = 1'b1;
            cnt_load_val = START_LD;
          end else begin
            state_nxt = resolve_move(btn_left, btn_right);
          end
        end
      end
      default: begin
        // Codes 6/7 recover immediately, independent of frame_tick.
        state_nxt = ST_IDLE;
        cnt_clr   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      attack_prev  <= 1'b0;
      hit_active   <= 1'b0;
      attack_busy  <= 1'b0;
      attack_pulse <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      if (frame_tick) attack_prev <= btn_attack;
      hit_active   <= (state_nxt == ST_ATTACK_ACTIVE);
      attack_busy  <= (state_nxt == ST_ATTACK_START) || (state_nxt == ST_ATTACK_ACTIVE) ||
                      (state_nxt == ST_ATTACK_RECOVERY);
      attack_pulse <= (state_nxt == ST_ATTACK_ACTIVE) && (state_q != ST_ATTACK_ACTIVE);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_fighter_state_fsm.sv
// Bench: default-timing and minimal (1/1/1) fighters share one stimulus stream,
// each compared against an attack-age reference model.
module tb_fighter_state_fsm;

  logic clk = 1'b0;
  logic rst_n;
  logic frame_tick, btn_left, btn_right, btn_attack;
  logic [2:0] st_d, st_m;
  logic hit_d, hit_m, busy_d, busy_m, pulse_d, pulse_m;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: attack timing expressed as an age in frames since the press.
  int       len_s [2] = '{4, 1};
  int       len_a [2] = '{2, 1};
  int       len_r [2] = '{6, 1};
  int       age   [2];
  int       mv    [2];
  bit       prev  [2];
  int       exp_state [2];
  bit       exp_pulse [2];

  always #5 clk = ~clk;

  fighter_state_fsm dut_d (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_attack(btn_attack),
    .state(st_d), .hit_active(hit_d), .attack_busy(busy_d), .attack_pulse(pulse_d)
  );

  fighter_state_fsm #(.START_FRAMES(1), .ACTIVE_FRAMES(1), .RECOVERY_FRAMES(1)) dut_m (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_attack(btn_attack),
    .state(st_m), .hit_active(hit_m), .attack_busy(busy_m), .attack_pulse(pulse_m)
  );

  function automatic int model_state(int k);
    if (age[k] < 0) return mv[k];
    if (age[k] < len_s[k]) return 3;
    if (age[k] < len_s[k] + len_a[k]) return 4;
    return 5;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      age[k] = -1; mv[k] = 0; prev[k] = 1'b0;
      exp_state[k] = 0; exp_pulse[k] = 1'b0;
    end
  endtask

  task automatic model_tick(input bit l, input bit r, input bit a);
    for (int k = 0; k < 2; k++) begin
      int  old_st;
      bit  edge_seen;
      bit  in_attack;
      old_st    = model_state(k);
      edge_seen = a && !prev[k];
      prev[k]   = a;
      in_attack = (age[k] >= 0) && (age[k] + 1 < len_s[k] + len_a[k] + len_r[k]);
      if (in_attack) age[k]++;
      else if (edge_seen) age[k] = 0;
      else begin
        age[k] = -1;
        mv[k]  = (l && !r) ? 1 : ((r && !l) ? 2 : 0);
      end
      exp_state[k] = model_state(k);
      exp_pulse[k] = (exp_state[k] == 4) && (old_st != 4);
    end
  endtask

  task automatic chk(input string tag, input int obs, input int expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("d_state", int'(st_d), exp_state[0]);
    chk("d_hit",   int'(hit_d), int'(exp_state[0] == 4));
    chk("d_busy",  int'(busy_d), int'(exp_state[0] >= 3 && exp_state[0] <= 5));
    chk("d_pulse", int'(pulse_d), int'(exp_pulse[0]));
    chk("m_state", int'(st_m), exp_state[1]);
    chk("m_hit",   int'(hit_m), int'(exp_state[1] == 4));
    chk("m_busy",  int'(busy_m), int'(exp_state[1] >= 3 && exp_state[1] <= 5));
    chk("m_pulse", int'(pulse_m), int'(exp_pulse[1]));
  endtask

  // Called at a negedge; applies inputs for one clk and checks at the following negedge.
  task automatic step(input bit tk, input bit l, input bit r, input bit a);
    frame_tick = tk; btn_left = l; btn_right = r; btn_attack = a;
    @(posedge clk);
    if (tk) model_tick(l, r, a);
    else begin
      exp_pulse[0] = 1'b0;
      exp_pulse[1] = 1'b0;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    frame_tick = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_attack = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Basic attack, with idle clks between some ticks.
    step(0, 0, 0, 0);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    for (int i = 0; i < 13; i++) begin
      step(1, 0, 0, 0);
      if (i % 3 == 0) step(0, 0, 0, 0);
    end

    // Movement.
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 1, 0);
      step(0, 0, 1, 0);
    end
    step(1, 1, 1, 0);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);

    // Held attack never retriggers; release then re-press starts a new one.
    for (int i = 0; i < 15; i++) step(1, 0, 0, 1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    for (int i = 0; i < 13; i++) step(1, 0, 0, 0);

    // Movement ignored during attack, honoured at recovery exit.
    step(1, 0, 0, 1);
    for (int i = 0; i < 14; i++) step(1, 0, 1, 0);

    // Press on the recovery-exit tick chains into a new attack.
    step(1, 0, 0, 1);
    for (int i = 0; i < 11; i++) step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    for (int i = 0; i < 13; i++) step(1, 0, 0, 0);

    // Reset mid ATTACK_ACTIVE.
    step(1, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
      if (i == 400) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
